// File: rtl/change_dispenser_pkg.sv
// Shared encodings for the change dispenser and the coin input side of the
// vending machine: coin codes on the hopper bus and the dispenser FSM states.
package change_dispenser_pkg;

    // Coin codes as seen on the hopper bus
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Dispenser FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_DIME   = 3'd2;
    localparam logic [2:0] ST_NICKEL = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_REJECT = 3'd5;

    // True for the states that present a coin to the hopper
    function automatic logic is_coin_state(input logic [2:0] st);
        return (st == ST_DIME) || (st == ST_NICKEL);
    endfunction

endpackage

// File: rtl/change_dispenser_stock.sv
// One coin stock counter: loadable and decremented once per coin ejected.
module coin_stock #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Restock has priority over a decrement; an empty stock never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount (in 5-cent units) using dimes first,
// then nickels, after confirming up front that the stock can cover it.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W   = 4,
    parameter int STOCK_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [AMT_W-1:0]   amount,
    input  logic               load_en,
    input  logic [STOCK_W-1:0] load_nickels,
    input  logic [STOCK_W-1:0] load_dimes,
    input  logic               coin_ready,
    output logic [1:0]         coin_out,
    output logic               coin_valid,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [STOCK_W-1:0] nickel_cnt,
    output logic [STOCK_W-1:0] dime_cnt
);

    // Wide enough for the amount, the stock and 2*d without overflow
    localparam int CW = ((AMT_W > STOCK_W) ? AMT_W : STOCK_W) + 2;

    logic [2:0]       state_reg, state_next;
    logic [AMT_W-1:0] remaining_reg, remaining_next;

    logic             xfer;
    logic             dime_dec, nickel_dec, stock_load;
    logic [CW-1:0]    rem_ext, dime_ext, nickel_ext, half_ext, d_sel, n_need;
    logic [AMT_W-1:0] rem_after_dime;
    logic [STOCK_W-1:0] dimes_after;

    assign xfer       = coin_ready && is_coin_state(state_reg);
    assign dime_dec   = xfer && (state_reg == ST_DIME);
    assign nickel_dec = xfer && (state_reg == ST_NICKEL);
    assign stock_load = (state_reg == ST_IDLE) && load_en && !req;

    // Feasibility check arithmetic: d = min(dimes, remaining/2), n = rest
    always_comb begin
        rem_ext    = CW'(remaining_reg);
        dime_ext   = CW'(dime_cnt);
        nickel_ext = CW'(nickel_cnt);
        half_ext   = rem_ext >> 1;
        d_sel      = (dime_ext < half_ext) ? dime_ext : half_ext;
        n_need     = rem_ext - (d_sel << 1);
    end

    assign rem_after_dime = remaining_reg - AMT_W'(2);
    assign dimes_after    = dime_cnt - STOCK_W'(1);

    // Next-state and remaining-amount logic
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    remaining_next = amount;
                    state_next     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (n_need > nickel_ext)
                    state_next = ST_REJECT;
                else if (d_sel != '0)
                    state_next = ST_DIME;
                else if (n_need != '0)
                    state_next = ST_NICKEL;
                else
                    state_next = ST_DONE;
            end
            ST_DIME: begin
                if (coin_ready) begin
                    remaining_next = rem_after_dime;
                    if ((rem_after_dime >= AMT_W'(2)) && (dimes_after != '0))
                        state_next = ST_DIME;
                    else if (rem_after_dime != '0)
                        state_next = ST_NICKEL;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_NICKEL: begin
                if (coin_ready) begin
                    remaining_next = remaining_reg - AMT_W'(1);
                    if (remaining_reg == AMT_W'(1))
                        state_next = ST_DONE;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            ST_REJECT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State and remaining-amount registers; reset aborts any payout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    coin_stock #(.W(STOCK_W)) u_nickels (
        .clk      (clk),
        .rst      (rst),
        .load     (stock_load),
        .load_val (load_nickels),
        .dec      (nickel_dec),
        .count    (nickel_cnt)
    );

    coin_stock #(.W(STOCK_W)) u_dimes (
        .clk      (clk),
        .rst      (rst),
        .load     (stock_load),
        .load_val (load_dimes),
        .dec      (dime_dec),
        .count    (dime_cnt)
    );

    // Outputs decode directly from the state register
    assign coin_valid = is_coin_state(state_reg);
    assign coin_out   = (state_reg == ST_DIME)   ? COIN_10 :
                        (state_reg == ST_NICKEL) ? COIN_5  : COIN_NONE;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign short      = (state_reg == ST_REJECT);

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter AMT_W, default 4: width of the change request, in 5-cent units (0..15).
REQ-002 Parameter STOCK_W, default 6: width of each coin stock counter (0..63 coins).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, 1: start a change payout; sampled only in IDLE.
REQ-006 Port amount, input, AMT_W: change owed in 5-cent units; sampled with req.
REQ-007 Port load_en, input, 1: restock strobe; honoured only in IDLE with req low.
REQ-008 Port load_nickels, input, STOCK_W: new nickel stock, written on load_en.
REQ-009 Port load_dimes, input, STOCK_W: new dime stock, written on load_en.
REQ-010 Port coin_ready, input, 1: coin hopper accepts the presented coin this cycle.
REQ-011 Port coin_out, output, 2: coin code 00 none, 01 nickel (5), 10 dime (10); 11 never driven.
REQ-012 Port coin_valid, output, 1: coin_out holds a coin to be ejected.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse when the payout completes.
REQ-015 Port short, output, 1: one-cycle pulse when a request is rejected for insufficient stock.
REQ-016 Ports nickel_cnt and dime_cnt, output, STOCK_W each: current stock levels.

Function
REQ-017 The block SHALL implement the states IDLE, CHECK, DIME, NICKEL, DONE and REJECT.
REQ-018 In IDLE, req=1 SHALL latch amount into remaining and move to CHECK on the next edge; load_en SHALL be ignored in that cycle.
REQ-019 In CHECK, d = min(dime_cnt, remaining/2) and n = remaining - 2*d; if n > nickel_cnt the block SHALL go to REJECT, else to DIME if d>0, NICKEL if n>0, DONE if remaining==0.
REQ-020 In DIME, the block SHALL drive coin_valid=1, coin_out=10 and hold both stable until coin_ready=1.
REQ-021 On a DIME transfer (coin_valid & coin_ready), remaining SHALL decrease by 2 and dime_cnt by 1; the next state is DIME if remaining>=2 and dime_cnt>0 after the update, else NICKEL if remaining>0, else DONE.
REQ-022 In NICKEL, the block SHALL drive coin_out=01 and coin_valid=1; each transfer SHALL decrease remaining and nickel_cnt by 1; the next state is DONE when remaining reaches 0.
REQ-023 Back-to-back transfers SHALL sustain one coin per cycle while coin_ready stays high.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE; REJECT SHALL assert short for exactly one cycle, dispense nothing, leave the stock unchanged, and return to IDLE.
REQ-025 When coin_valid=0, coin_out SHALL be 00; coin_ready SHALL be ignored outside DIME and NICKEL.
REQ-026 req while busy=1 SHALL be ignored; it is not queued.
REQ-027 amount=0 SHALL give CHECK, then DONE with a done pulse and no coins.
REQ-028 Stock counters SHALL never wrap: the CHECK gate guarantees no decrement occurs at zero.
REQ-029 Arithmetic SHALL use widths of AMT_W+1 bits minimum so that 2*d cannot overflow.

Reset
REQ-030 rst=1 SHALL force state=IDLE, remaining=0, coin_out=00, coin_valid=0, busy=0, done=0, short=0, nickel_cnt=0 and dime_cnt=0, with priority over all other inputs.
REQ-031 rst during a payout SHALL abort it at once; coins already transferred are not refunded to the stock.

Structure
REQ-032 The coin encodings (COIN_NONE=00, COIN_5=01, COIN_10=10) and the state encodings SHALL live in a shared package, also used by the vending machine coin input side.
REQ-033 Each stock counter SHALL be an instance of the sub-module coin_stock (load, decrement, count output), instantiated twice.

Verification
REQ-034 Stock 5N/5D loaded, amount=3, coin_ready=1 -> coins 10 then 01 in consecutive cycles, done pulse, final stock 4N/4D.
REQ-035 Stock 5N/0D, amount=3 -> three 01 coins, done pulse, final nickel_cnt=2.
REQ-036 Stock 1N/1D, amount=4 -> short pulse, no coin_valid, stock unchanged at 1N/1D.
REQ-037 Stock 2N/2D, amount=2, coin_ready held low 4 cycles then high -> coin_out=10 stable with coin_valid=1 throughout, one transfer, then done.
REQ-038 amount=5 with stock 9N/9D, rst asserted after the first dime transfer -> next cycle all outputs and counters are at reset values; a new load and req then behave normally.
REQ-039 amount=0 -> done pulse 2 cycles after req, no coins; req and load_en asserted while busy -> no effect.
